// File: rtl/ahb_usb_pkg.sv
// rtl/ahb_usb_pkg.sv - shared constants and types for the AHB-lite USB slave FIFO
package ahb_usb_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_IRQ_EN = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam int ST_RX_DATA_READY = 0;
  localparam int ST_RX_ACTIVE     = 1;
  localparam int ST_TX_ACTIVE     = 2;
  localparam int ST_RX_ERROR      = 3;
  localparam int ST_TX_ERROR      = 4;
  localparam int ST_RX_OVERFLOW   = 5;

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_DATA = 2'd1, TX_ACK = 2'd2, TX_NAK = 2'd3} tx_cmd_t;
  typedef enum logic [1:0] {S_OKAY = 2'd0, S_ERR1 = 2'd1, S_ERR2 = 2'd2} err_state_t;

  function automatic logic [2:0] size_bytes(input logic [2:0] hsize);
    case (hsize)
      HSIZE_BYTE: return 3'd1;
      HSIZE_HALF: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [2:0] hsize);
    case (hsize)
      HSIZE_BYTE: return 32'h0000_00ff;
      HSIZE_HALF: return 32'h0000_ffff;
      default:    return 32'hffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/usb_byte_fifo.sv
// rtl/usb_byte_fifo.sv - byte FIFO with a 1-4 byte bus port and a 1-byte USB port
module usb_byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     flush,
  input  logic                     ahb_push,
  input  logic                     ahb_pop,
  input  logic [2:0]               ahb_len,
  input  logic [31:0]              ahb_wdata,
  output logic [31:0]              ahb_rdata,
  input  logic                     usb_push,
  input  logic [7:0]               usb_wdata,
  output logic                     usb_drop,
  input  logic                     usb_pop,
  output logic [7:0]               usb_rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    push_len, pop_len;
  logic          usb_push_ok, usb_pop_ok;

  // USB-side byte queues behind any same-cycle bus access so the pair never over/underflows
  always_comb begin
    push_len    = ahb_push ? ahb_len : 3'd0;
    pop_len     = ahb_pop ? ahb_len : 3'd0;
    usb_push_ok = usb_push && ((32'(count) + 32'(push_len)) < 32'(DEPTH));
    usb_pop_ok  = usb_pop && (32'(count) > 32'(pop_len));
  end

  assign usb_drop  = usb_push && !usb_push_ok;
  assign usb_rdata = (count == '0) ? 8'h00 : mem[rd_ptr];

  for (genvar g = 0; g < 4; g++) begin : g_peek
    assign ahb_rdata[8*g +: 8] = mem[rd_ptr + AW'(g)];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ahb_push && (i < int'(ahb_len)))
        mem[wr_ptr + AW'(i)] <= ahb_wdata[8*i +: 8];
    if (usb_push_ok)
      mem[wr_ptr + AW'(push_len)] <= usb_wdata;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_len) + AW'(usb_push_ok);
      rd_ptr <= rd_ptr + AW'(pop_len) + AW'(usb_pop_ok);
      count  <= count + (AW+1)'(push_len) + (AW+1)'(usb_push_ok)
                      - (AW+1)'(pop_len) - (AW+1)'(usb_pop_ok);
    end
  end

endmodule

// File: rtl/ahb_usb_slave_fifo.sv
// rtl/ahb_usb_slave_fifo.sv - AHB-lite slave front-end: data phase, error FSM, registers, TX command
module ahb_usb_slave_fifo
  import ahb_usb_pkg::*;
#(
  parameter int BUF_DEPTH = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        hsel,
  input  logic        hwrite,
  input  logic [3:0]  haddr,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp,
  input  logic        rx_store,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_ready,
  input  logic        rx_active,
  input  logic        rx_error,
  input  logic        tx_get,
  output logic [7:0]  tx_data,
  input  logic        tx_active,
  input  logic        tx_error,
  output logic [1:0]  tx_packet,
  output logic        irq
);
  localparam int AW = $clog2(BUF_DEPTH);

  logic              dp_valid, dp_write, dp_err, dp_ok, accept;
  logic [3:0]        dp_addr;
  logic [2:0]        dp_size, nbytes;
  logic [1:0]        reg_sel;
  err_state_t        state, phase, state_next;
  logic [AW:0]       count;
  logic [31:0]       fifo_peek;
  logic              usb_drop, rx_overflow, ctrl_wr, tx_fire;
  logic [5:0]        irq_en, status;
  tx_cmd_t           pending;
  logic              unused;

  assign unused  = htrans[0];
  assign reg_sel = dp_addr[3:2];
  assign nbytes  = size_bytes(dp_size);
  assign accept  = hsel && htrans[1] && hready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_size  <= '0;
    end else begin
      dp_valid <= accept;
      if (accept) begin
        dp_write <= hwrite;
        dp_addr  <= haddr;
        dp_size  <= hsize;
      end
    end
  end

  always_comb begin
    dp_err = 1'b0;
    if (dp_valid) begin
      if (dp_size > HSIZE_WORD) dp_err = 1'b1;
      else if (dp_size == HSIZE_HALF && dp_addr[0]) dp_err = 1'b1;
      else if (dp_size == HSIZE_WORD && dp_addr[1:0] != 2'b00) dp_err = 1'b1;
      else if (dp_write && reg_sel == REG_STATUS) dp_err = 1'b1;
      else if (reg_sel == REG_DATA && !dp_write && 32'(count) < 32'(nbytes)) dp_err = 1'b1;
      else if (reg_sel == REG_DATA && dp_write && (32'(count) + 32'(nbytes)) > 32'(BUF_DEPTH)) dp_err = 1'b1;
    end
  end
  assign dp_ok = dp_valid && !dp_err;

  // ERR1 is the faulting data phase itself, so it is decoded rather than stored
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_OKAY;
    else        state <= state_next;
  end

  always_comb begin
    phase      = (state == S_OKAY && dp_err) ? S_ERR1 : state;
    state_next = S_OKAY;
    hready     = 1'b1;
    hresp      = 1'b0;
    case (phase)
      S_ERR1: begin
        hready     = 1'b0;
        hresp      = 1'b1;
        state_next = S_ERR2;
      end
      S_ERR2:  hresp = 1'b1;
      default: ;
    endcase
  end

  assign status  = {rx_overflow, tx_error, rx_error, tx_active, rx_active, rx_data_ready};
  assign ctrl_wr = dp_ok && dp_write && reg_sel == REG_CTRL;
  assign tx_fire = (pending != TX_IDLE) && !tx_active;
  assign tx_packet = tx_fire ? pending : TX_IDLE;

  always_comb begin
    hrdata = '0;
    if (dp_ok && !dp_write) begin
      case (reg_sel)
        REG_DATA:   hrdata = (fifo_peek & lane_mask(dp_size)) << {dp_addr[1:0], 3'b000};
        REG_STATUS: hrdata = {16'h0000, 8'(count), 2'b00, status};
        REG_CTRL:   hrdata = {30'h0, pending};
        default:    hrdata = {26'h0, irq_en};
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_overflow <= 1'b0;
      irq_en      <= '0;
      pending     <= TX_IDLE;
      irq         <= 1'b0;
    end else begin
      irq <= |(status & irq_en);
      if (usb_drop) rx_overflow <= 1'b1;
      else if (ctrl_wr && hwdata[3]) rx_overflow <= 1'b0;
      if (dp_ok && dp_write && reg_sel == REG_IRQ_EN) irq_en <= hwdata[5:0];
      if (ctrl_wr && hwdata[1:0] != 2'b00) pending <= tx_cmd_t'(hwdata[1:0]);
      else if (tx_fire) pending <= TX_IDLE;
    end
  end

  usb_byte_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .flush     (ctrl_wr && hwdata[2]),
    .ahb_push  (dp_ok && dp_write && reg_sel == REG_DATA),
    .ahb_pop   (dp_ok && !dp_write && reg_sel == REG_DATA),
    .ahb_len   (nbytes),
    .ahb_wdata (hwdata >> {dp_addr[1:0], 3'b000}),
    .ahb_rdata (fifo_peek),
    .usb_push  (rx_store),
    .usb_wdata (rx_data),
    .usb_drop  (usb_drop),
    .usb_pop   (tx_get),
    .usb_rdata (tx_data),
    .count     (count)
  );

endmodule

// File: tb/tb_ahb_usb_slave_fifo.sv
// tb/tb_ahb_usb_slave_fifo.sv - directed self-checking bench for ahb_usb_slave_fifo
module tb_ahb_usb_slave_fifo;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        hsel, hwrite;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata, hrdata;
  logic        hready, hresp;
  logic        rx_store, rx_data_ready, rx_active, rx_error;
  logic [7:0]  rx_data, tx_data;
  logic        tx_get, tx_active, tx_error;
  logic [1:0]  tx_packet;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb_usb_slave_fifo #(.BUF_DEPTH(64)) dut (
    .clk(clk), .n_rst(n_rst), .hsel(hsel), .hwrite(hwrite), .haddr(haddr),
    .htrans(htrans), .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata),
    .hready(hready), .hresp(hresp), .rx_store(rx_store), .rx_data(rx_data),
    .rx_data_ready(rx_data_ready), .rx_active(rx_active), .rx_error(rx_error),
    .tx_get(tx_get), .tx_data(tx_data), .tx_active(tx_active), .tx_error(tx_error),
    .tx_packet(tx_packet), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ahb(input string tag, input logic wr, input logic [3:0] a, input logic [2:0] sz,
                     input logic [31:0] wd, input logic exp_err, output logic [31:0] rd);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    @(negedge clk);
    rd = hrdata;
    chk({tag, "_hresp"}, 32'(hresp), 32'(exp_err));
    if (hresp) begin
      chk({tag, "_err1_hready"}, 32'(hready), 32'd0);
      @(negedge clk);
      chk({tag, "_err2_hready"}, 32'(hready), 32'd1);
      chk({tag, "_err2_hresp"}, 32'(hresp), 32'd1);
    end else begin
      chk({tag, "_hready"}, 32'(hready), 32'd1);
    end
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk); rx_store = 1'b1; rx_data = b;
    @(negedge clk); rx_store = 1'b0;
  endtask

  task automatic tx_pop(output logic [7:0] b);
    @(negedge clk); b = tx_data; tx_get = 1'b1;
    @(negedge clk); tx_get = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    n_rst = 1'b0; hsel = 0; hwrite = 0; haddr = 0; htrans = 0; hsize = 0; hwdata = 0;
    rx_store = 0; rx_data = 0; rx_data_ready = 0; rx_active = 0; rx_error = 0;
    tx_get = 0; tx_active = 0; tx_error = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hready", 32'(hready), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_tx_packet", 32'(tx_packet), 32'd0);
    n_rst = 1'b1;

    ahb("rst_status", 1'b0, 4'h4, 3'd2, 32'h0, 1'b0, rd);
    chk("rst_status_val", rd, 32'h0000_0000);
    chk("empty_tx_data", 32'(tx_data), 32'h0);

    ahb("wr_word", 1'b1, 4'h0, 3'd2, 32'h4433_2211, 1'b0, rd);
    tx_pop(b); chk("tx_byte0", 32'(b), 32'h11);
    tx_pop(b); chk("tx_byte1", 32'(b), 32'h22);
    tx_pop(b); chk("tx_byte2", 32'(b), 32'h33);
    tx_pop(b); chk("tx_byte3", 32'(b), 32'h44);
    ahb("occ_after_tx", 1'b0, 4'h4, 3'd2, 32'h0, 1'b0, rd);
    chk("occ_after_tx_val", rd, 32'h0000_0000);

    rx_push(8'hA1); rx_push(8'hA2); rx_push(8'hA3);
    ahb("rd_word_short", 1'b0, 4'h0, 3'd2, 32'h0, 1'b1, rd);
    ahb("occ3", 1'b0, 4'h4, 3'd2, 32'h0, 1'b0, rd);
    chk("occ3_val", rd, 32'h0000_0300);
    ahb("rd_half2", 1'b0, 4'h2, 3'd1, 32'h0, 1'b0, rd);
    chk("rd_half2_val", rd, 32'hA2A1_0000);
    ahb("rd_byte1", 1'b0, 4'h1, 3'd0, 32'h0, 1'b0, rd);
    chk("rd_byte1_val", rd, 32'h0000_A300);
    ahb("misaligned_half", 1'b0, 4'h1, 3'd1, 32'h0, 1'b1, rd);
    ahb("status_write", 1'b1, 4'h4, 3'd2, 32'hFFFF_FFFF, 1'b1, rd);
    ahb("hsize3", 1'b0, 4'h4, 3'd3, 32'h0, 1'b1, rd);
    ahb("occ0", 1'b0, 4'h4, 3'd2, 32'h0, 1'b0, rd);
    chk("occ0_val", rd, 32'h0000_0000);

    ahb("irq_en_wr", 1'b1, 4'hC, 3'd2, 32'h20, 1'b0, rd);
    ahb("irq_en_rd", 1'b0, 4'hC, 3'd2, 32'h0, 1'b0, rd);
    chk("irq_en_val", rd, 32'h0000_0020);
    for (int i = 0; i < 16; i++)
      ahb("fill", 1'b1, 4'h0, 3'd2, 32'h0302_0100 + 32'(i) * 32'h0404_0404, 1'b0, rd);
    ahb("occ_full", 1'b0, 4'h4, 3'd2, 32'h0, 1'b0, rd);
    chk("occ_full_val", rd, 32'h0000_4000);
    ahb("wr_full", 1'b1, 4'h0, 3'd0, 32'hEE, 1'b1, rd);
    rx_push(8'hEE);
    chk("irq_delay", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'd1);
    ahb("status_ovf", 1'b0, 4'h4, 3'd2, 32'h0, 1'b0, rd);
    chk("status_ovf_val", rd, 32'h0000_4020);
    ahb("ovf_clear", 1'b1, 4'h8, 3'd2, 32'h8, 1'b0, rd);
    ahb("status_clr", 1'b0, 4'h4, 3'd2, 32'h0, 1'b0, rd);
    chk("status_clr_val", rd, 32'h0000_4000);
    chk("irq_clr", 32'(irq), 32'd0);
    ahb("rd_wrap_word", 1'b0, 4'h0, 3'd2, 32'h0, 1'b0, rd);
    chk("rd_wrap_word_val", rd, 32'h0302_0100);

    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 4'h8; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h4; rx_store = 1'b1; rx_data = 8'h5A;
    @(negedge clk);
    chk("flush_hresp", 32'(hresp), 32'd0);
    @(posedge clk); #1;
    rx_store = 1'b0;
    ahb("occ_flush", 1'b0, 4'h4, 3'd2, 32'h0, 1'b0, rd);
    chk("occ_flush_val", rd, 32'h0000_0000);

    @(negedge clk); tx_active = 1'b1;
    ahb("tx_cmd", 1'b1, 4'h8, 3'd2, 32'h1, 1'b0, rd);
    @(negedge clk);
    chk("tx_hold", 32'(tx_packet), 32'd0);
    ahb("pending_rd", 1'b0, 4'h8, 3'd2, 32'h0, 1'b0, rd);
    chk("pending_val", rd, 32'h0000_0001);
    ahb("status_txact", 1'b0, 4'h4, 3'd2, 32'h0, 1'b0, rd);
    chk("status_txact_val", rd, 32'h0000_0004);
    @(negedge clk); tx_active = 1'b0; #1;
    chk("tx_pulse", 32'(tx_packet), 32'd1);
    @(negedge clk);
    chk("tx_pulse_end", 32'(tx_packet), 32'd0);
    ahb("pending_clr", 1'b0, 4'h8, 3'd2, 32'h0, 1'b0, rd);
    chk("pending_clr_val", rd, 32'h0000_0000);

    @(negedge clk); tx_active = 1'b1;
    ahb("tx_cmd_ack", 1'b1, 4'h8, 3'd2, 32'h2, 1'b0, rd);
    ahb("tx_cmd_nak", 1'b1, 4'h8, 3'd2, 32'h3, 1'b0, rd);
    @(negedge clk); tx_active = 1'b0; #1;
    chk("tx_overwrite", 32'(tx_packet), 32'd3);
    @(negedge clk);
    chk("tx_overwrite_end", 32'(tx_packet), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
